// File: rtl/network_sequencer_if.sv
// Valid/ready vector channels between a host and the network sequencer:
// input vectors flow host->sequencer, captured results flow sequencer->host.
interface network_sequencer_if #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1
);
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data [INPUT_SIZE];
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data [OUTPUT_SIZE];

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/network_sequencer.sv
// Control stage for the bitstream network: latches one input vector, strobes the
// integrators around an accumulate window, and hands the captured counts back.
module network_sequencer #(
  parameter int INPUT_SIZE  = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int WARMUP      = 4,
  parameter int WINDOW      = 256,
  parameter int CAPTURE_LAT = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  network_sequencer_if.slave  host,
  input  logic                abort,
  output logic signed [31:0]  net_input  [INPUT_SIZE],
  output logic                compute,
  input  logic signed [31:0]  net_output [OUTPUT_SIZE],
  output logic                busy,
  output logic [15:0]         result_count
);

  localparam int MAX_AB  = (WARMUP > WINDOW) ? WARMUP : WINDOW;
  localparam int MAX_CNT = (MAX_AB > CAPTURE_LAT) ? MAX_AB : CAPTURE_LAT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARM,
    S_FLUSH,
    S_RUN,
    S_END,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic               accept;
  logic               capture;
  logic               deliver;
  logic signed [31:0] out_data_q [OUTPUT_SIZE];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Abort outranks every state transition, so a cancelled transaction never
  // strobes the integrators or delivers a result.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    deliver    = 1'b0;
    compute    = 1'b0;
    if (state != S_IDLE && abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.in_valid && !abort) begin
            accept = 1'b1;
            if (WARMUP == 0) begin
              state_next = S_FLUSH;
            end else begin
              state_next = S_WARM;
              cnt_next   = CW'(WARMUP);
            end
          end
        end
        S_WARM: begin
          if (cnt == CW'(1)) state_next = S_FLUSH;
          else               cnt_next   = cnt - CW'(1);
        end
        S_FLUSH: begin
          compute    = 1'b1;
          state_next = S_RUN;
          cnt_next   = CW'(WINDOW);
        end
        S_RUN: begin
          if (cnt == CW'(1)) state_next = S_END;
          else               cnt_next   = cnt - CW'(1);
        end
        S_END: begin
          compute    = 1'b1;
          state_next = S_WAIT;
          cnt_next   = CW'(CAPTURE_LAT);
        end
        S_WAIT: begin
          if (cnt == CW'(1)) begin
            capture    = 1'b1;
            state_next = S_DONE;
          end else begin
            cnt_next = cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (host.out_ready) begin
            deliver    = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < INPUT_SIZE; i++) net_input[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < INPUT_SIZE; i++) net_input[i] <= host.in_data[i];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) out_data_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) out_data_q[i] <= net_output[i];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       result_count <= '0;
    else if (deliver) result_count <= result_count + 16'd1;
  end

  assign host.in_ready  = (state == S_IDLE);
  assign host.out_valid = (state == S_DONE);
  assign host.out_data  = out_data_q;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_network_sequencer.sv
// Self-checking bench: two sequencer instances with different timing, a cycle-timed
// network model, and a scoreboard of expected results per accepted vector.
module tb_network_sequencer;

  localparam int A_W   = 2;
  localparam int A_WIN = 16;
  localparam int A_CL  = 1;
  localparam int A_L   = A_W + A_WIN + A_CL + 2;
  localparam int B_W   = 0;
  localparam int B_WIN = 1;
  localparam int B_CL  = 1;
  localparam int B_L   = B_W + B_WIN + B_CL + 2;

  typedef struct {
    int d0;
    int d1;
    int data;
  } exp_t;

  typedef struct {
    int d0;
    int d1;
    int pay;
    int hold;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   count_exp_a = 0;
  int   count_exp_b = 0;
  int   cap_a = -1;
  int   pay_a = 0;
  int   cap_b = -1;
  int   pay_b = 0;
  int   e0_a = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  network_sequencer_if #(.INPUT_SIZE(2), .OUTPUT_SIZE(1)) ha ();
  network_sequencer_if #(.INPUT_SIZE(2), .OUTPUT_SIZE(1)) hb ();

  logic               abort_a, abort_b;
  logic               compute_a, compute_b;
  logic               busy_a, busy_b;
  logic signed [31:0] net_in_a [2];
  logic signed [31:0] net_in_b [2];
  logic signed [31:0] net_out_a [1];
  logic signed [31:0] net_out_b [1];
  logic [15:0]        count_a, count_b;

  network_sequencer #(
    .INPUT_SIZE(2), .OUTPUT_SIZE(1), .WARMUP(A_W), .WINDOW(A_WIN), .CAPTURE_LAT(A_CL)
  ) dut_a (
    .clk(clk), .n_rst(n_rst), .host(ha), .abort(abort_a), .net_input(net_in_a),
    .compute(compute_a), .net_output(net_out_a), .busy(busy_a), .result_count(count_a)
  );

  network_sequencer #(
    .INPUT_SIZE(2), .OUTPUT_SIZE(1), .WARMUP(B_W), .WINDOW(B_WIN), .CAPTURE_LAT(B_CL)
  ) dut_b (
    .clk(clk), .n_rst(n_rst), .host(hb), .abort(abort_b), .net_input(net_in_b),
    .compute(compute_b), .net_output(net_out_b), .busy(busy_b), .result_count(count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Network model: the expected count is present only in the last cycle before capture.
  always @(negedge clk) begin
    net_out_a[0] = (cyc == cap_a) ? pay_a : 32'h7000_0000 + cyc;
    net_out_b[0] = (cyc == cap_b) ? pay_b : 32'h6000_0000 + cyc;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int d0, input int d1, input int pay);
    int n = 0;
    while (ha.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checkOutput("a_in_ready_before_accept", ha.in_ready, 1);
    ha.in_valid   = 1'b1;
    ha.in_data[0] = d0;
    ha.in_data[1] = d1;
    step();
    ha.in_valid = 1'b0;
    e0_a  = cyc;
    cap_a = e0_a + A_L - 1;
    pay_a = pay;
    sb_a.push_back('{d0: d0, d1: d1, data: pay});
  endtask

  task automatic watch_a(input int d0, input int d1, input int last_k);
    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) step();
      checkOutput("a_compute", compute_a, (k == A_W || k == A_W + A_WIN + 1) ? 1 : 0);
      checkOutput("a_out_valid", ha.out_valid, (k >= A_L) ? 1 : 0);
      checkOutput("a_busy", busy_a, 1);
      checkOutput("a_net_input0", net_in_a[0], d0);
      checkOutput("a_net_input1", net_in_a[1], d1);
    end
  endtask

  task automatic finish_a(input int hold);
    exp_t e;
    ha.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      ha.in_valid   = h[0];
      ha.in_data[0] = 1000 + h;
      ha.in_data[1] = 2000 + h;
      step();
      checkOutput("a_bp_out_valid", ha.out_valid, 1);
      checkOutput("a_bp_in_ready", ha.in_ready, 0);
      checkOutput("a_bp_out_data", ha.out_data[0], pay_a);
    end
    ha.in_valid = 1'b0;
    if (sb_a.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL a_scoreboard: result with no expected entry (cycle %0d)", cyc);
    end else begin
      e = sb_a.pop_front();
      checkOutput("a_out_data", ha.out_data[0], e.data);
      checkOutput("a_held_input0", net_in_a[0], e.d0);
      checkOutput("a_held_input1", net_in_a[1], e.d1);
    end
    ha.out_ready = 1'b1;
    step();
    ha.out_ready = 1'b0;
    count_exp_a++;
    checkOutput("a_out_valid_after_hs", ha.out_valid, 0);
    checkOutput("a_result_count", count_a, count_exp_a & 16'hFFFF);
    checkOutput("a_in_ready_after_hs", ha.in_ready, 1);
  endtask

  task automatic run_b(input int d0, input int d1, input int pay);
    exp_t e;
    int n = 0;
    while (hb.in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checkOutput("b_in_ready_before_accept", hb.in_ready, 1);
    hb.in_valid   = 1'b1;
    hb.in_data[0] = d0;
    hb.in_data[1] = d1;
    step();
    hb.in_valid = 1'b0;
    cap_b = cyc + B_L - 1;
    pay_b = pay;
    sb_b.push_back('{d0: d0, d1: d1, data: pay});
    for (int k = 0; k <= B_L; k++) begin
      if (k > 0) step();
      checkOutput("b_compute", compute_b, (k == B_W || k == B_W + B_WIN + 1) ? 1 : 0);
      checkOutput("b_out_valid", hb.out_valid, (k >= B_L) ? 1 : 0);
      checkOutput("b_busy", busy_b, 1);
    end
    e = sb_b.pop_front();
    checkOutput("b_out_data", hb.out_data[0], e.data);
    checkOutput("b_net_input0", net_in_b[0], e.d0);
    checkOutput("b_net_input1", net_in_b[1], e.d1);
    hb.out_ready = 1'b1;
    step();
    hb.out_ready = 1'b0;
    count_exp_b++;
    checkOutput("b_result_count", count_b, count_exp_b & 16'hFFFF);
    checkOutput("b_in_ready_after_hs", hb.in_ready, 1);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_in_ready", ha.in_ready, 1);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_compute", compute_a, 0);
    checkOutput("rst_out_valid", ha.out_valid, 0);
    checkOutput("rst_net_input0", net_in_a[0], 0);
    checkOutput("rst_net_input1", net_in_a[1], 0);
    checkOutput("rst_out_data", ha.out_data[0], 0);
    checkOutput("rst_result_count", count_a, 0);
    checkOutput("rst_b_result_count", count_b, 0);
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{d0: 128, d1: 64, pay: 9, hold: 0};
    vecs[1] = '{d0: 128, d1: 64, pay: 9, hold: 50};
    vecs[2] = '{d0: -5, d1: 7, pay: 16, hold: 3};
    vecs[3] = '{d0: 0, d1: 32'h7FFF_FFFF, pay: 0, hold: 1};

    n_rst = 1'b0;
    abort_a = 1'b0;
    abort_b = 1'b0;
    ha.in_valid = 1'b0;
    ha.out_ready = 1'b0;
    ha.in_data[0] = 0;
    ha.in_data[1] = 0;
    hb.in_valid = 1'b0;
    hb.out_ready = 1'b0;
    hb.in_data[0] = 0;
    hb.in_data[1] = 0;
    step();
    step();
    check_reset_values();
    n_rst = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].d0, vecs[i].d1, vecs[i].pay);
      watch_a(vecs[i].d0, vecs[i].d1, A_L);
      finish_a(vecs[i].hold);
    end

    // Abort in the fifth RUN cycle: no END strobe, no result, count untouched.
    applyStimulus(11, 22, 5);
    watch_a(11, 22, A_W + 1 + 4);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    void'(sb_a.pop_back());
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_in_ready", ha.in_ready, 1);
    for (int i = 0; i < 30; i++) begin
      step();
      checkOutput("abort_no_compute", compute_a, 0);
      checkOutput("abort_no_out_valid", ha.out_valid, 0);
    end
    checkOutput("abort_count", count_a, count_exp_a);

    // Abort during FLUSH must suppress the strobe in that same cycle.
    applyStimulus(33, 44, 7);
    watch_a(33, 44, A_W - 1);
    step();
    abort_a = 1'b1;
    #1;
    checkOutput("abort_flush_compute", compute_a, 0);
    step();
    void'(sb_a.pop_back());
    checkOutput("abort_flush_busy", busy_a, 0);

    // Abort held in IDLE blocks acceptance.
    ha.in_valid = 1'b1;
    ha.in_data[0] = 77;
    ha.in_data[1] = 88;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("idle_abort_busy", busy_a, 0);
      checkOutput("idle_abort_net_input0", net_in_a[0], 33);
    end
    ha.in_valid = 1'b0;
    abort_a = 1'b0;
    step();

    // Reset mid-RUN drops everything, then a fresh vector sees full latency.
    applyStimulus(3, 4, 6);
    watch_a(3, 4, 8);
    run_b(1, 2, 3);
    n_rst = 1'b0;
    #1;
    check_reset_values();
    sb_a.delete();
    count_exp_a = 0;
    count_exp_b = 0;
    step();
    n_rst = 1'b1;
    step();
    applyStimulus(128, 64, 9);
    watch_a(128, 64, A_L);
    finish_a(0);

    for (int i = 0; i < 6; i++) begin
      run_b(10 * i, -i, 100 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
